// File: rtl/key_event_if.sv
// Key event bundle: debounced key inputs toward the decoder, gesture pulses and busy back out.
interface key_event_if;
  logic key_flag;
  logic key_state;
  logic single_click;
  logic double_click;
  logic long_press;
  logic long_repeat;
  logic key_busy;

  modport master (
    output key_flag, key_state,
    input  single_click, double_click, long_press, long_repeat, key_busy
  );

  modport slave (
    input  key_flag, key_state,
    output single_click, double_click, long_press, long_repeat, key_busy
  );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies debounced key edges into single/double click, long press and auto-repeat pulses.
// IDLE: no gesture | PRESS1: first press held | WAIT2: released, awaiting second press | PRESS2: second press held | LONG: long press held
module key_event_decoder #(
  parameter int LONG_CYC   = 50_000_000,
  parameter int DCLICK_CYC = 15_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int CNT_W      = 26
) (
  input logic       clk,
  input logic       rst,
  key_event_if.slave kif
);

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             single_q, single_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             restart;
  logic             press_ev, rel_ev;

  assign press_ev = kif.key_flag & ~kif.key_state;
  assign rel_ev   = kif.key_flag &  kif.key_state;

  always_comb begin
    state_d  = state_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    restart  = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_ev) state_d = PRESS1;
      end
      PRESS1: begin
        if (rel_ev) begin
          state_d = WAIT2;
        end else if (cnt_q == LONG_TC) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end
      WAIT2: begin
        if (press_ev) begin
          state_d = PRESS2;
        end else if (cnt_q == DCLICK_TC) begin
          state_d  = IDLE;
          single_d = 1'b1;
        end
      end
      PRESS2: begin
        if (rel_ev) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end
      end
      LONG: begin
        if (rel_ev) begin
          state_d = IDLE;
        end else if (cnt_q == REPEAT_TC) begin
          repeat_d = 1'b1;
          restart  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        restart = 1'b1;
      end
    endcase

    // Timer restarts on any state change or repeat period; it only runs in timed states.
    if (state_d != state_q || restart) begin
      cnt_d = '0;
    end else if (state_q == PRESS1 || state_q == WAIT2 || state_q == LONG) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
    end
  end

  assign kif.single_click = single_q;
  assign kif.double_click = double_q;
  assign kif.long_press   = long_q;
  assign kif.long_repeat  = repeat_q;
  assign kif.key_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed gesture stimulus; expected pulses (kind + cycle) are queued and checked by a monitor.
module tb_key_event_decoder;

  localparam int LONG_CYC   = 100;
  localparam int DCLICK_CYC = 40;
  localparam int REPEAT_CYC = 20;

  localparam logic [3:0] M_SINGLE = 4'b0001;
  localparam logic [3:0] M_DOUBLE = 4'b0010;
  localparam logic [3:0] M_LONG   = 4'b0100;
  localparam logic [3:0] M_REP    = 4'b1000;

  typedef struct {
    logic [3:0] mask;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  exp_t exp_q[$];

  key_event_if kif ();

  key_event_decoder #(
    .LONG_CYC  (LONG_CYC),
    .DCLICK_CYC(DCLICK_CYC),
    .REPEAT_CYC(REPEAT_CYC),
    .CNT_W     (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kif(kif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] pulses();
    return {kif.long_repeat, kif.long_press, kif.double_click, kif.single_click};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic ev(input logic st, output int c);
    kif.key_state = st;
    kif.key_flag  = 1'b1;
    c = cyc;
    tick();
    kif.key_flag = 1'b0;
  endtask

  task automatic push(input logic [3:0] m, input int c);
    exp_t e;
    e.mask = m;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && (pulses() != 4'b0000)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got %b want none (cycle %0d)", pulses(), cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", {28'd0, pulses()}, {28'd0, e.mask});
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int p, r, q, s;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    kif.key_flag  = 1'b0;
    kif.key_state = 1'b1;

    // Reset held three cycles while a press arrives
    tick();
    ev(1'b0, p);
    tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", kif.key_busy, 1'b0);
    chk("reset_outputs", pulses(), 4'b0000);
    ev(1'b1, r);
    wait_until(r + 5);
    chk("idle_rel_ignored", kif.key_busy, 1'b0);

    // Reset mid PRESS1 discards the gesture
    ev(1'b0, p);
    wait_until(p + 10);
    chk("press1_busy", kif.key_busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", kif.key_busy, 1'b0);
    wait_until(p + 150);
    ev(1'b1, r);
    wait_until(r + 60);
    chk("rst_mid_idle", kif.key_busy, 1'b0);

    // Single click
    ev(1'b0, p);
    wait_until(p + 30);
    ev(1'b1, r);
    push(M_SINGLE, r + DCLICK_CYC + 1);
    wait_until(r + 20);
    chk("wait2_busy", kif.key_busy, 1'b1);
    wait_until(r + 60);
    chk("single_done_busy", kif.key_busy, 1'b0);

    // Double click
    ev(1'b0, p);
    wait_until(p + 30);
    ev(1'b1, r);
    wait_until(r + 20);
    ev(1'b0, q);
    wait_until(q + 10);
    ev(1'b1, s);
    push(M_DOUBLE, s + 1);
    wait_until(s + 60);

    // Second press exactly on the last WAIT2 cycle still makes a double click
    ev(1'b0, p);
    wait_until(p + 30);
    ev(1'b1, r);
    wait_until(r + DCLICK_CYC);
    ev(1'b0, q);
    wait_until(q + 5);
    ev(1'b1, s);
    push(M_DOUBLE, s + 1);
    wait_until(s + 60);

    // Press one cycle too late: single click, then a fresh gesture
    ev(1'b0, p);
    wait_until(p + 30);
    ev(1'b1, r);
    push(M_SINGLE, r + DCLICK_CYC + 1);
    wait_until(r + DCLICK_CYC + 1);
    ev(1'b0, q);
    chk("late_press_busy", kif.key_busy, 1'b1);
    wait_until(q + 10);
    ev(1'b1, s);
    push(M_SINGLE, s + DCLICK_CYC + 1);
    wait_until(s + 60);

    // Long press with auto-repeat
    ev(1'b0, p);
    push(M_LONG, p + LONG_CYC + 1);
    push(M_REP, p + LONG_CYC + 1 + REPEAT_CYC);
    push(M_REP, p + LONG_CYC + 1 + 2 * REPEAT_CYC);
    push(M_REP, p + LONG_CYC + 1 + 3 * REPEAT_CYC);
    wait_until(p + 164);
    chk("long_busy", kif.key_busy, 1'b1);
    wait_until(p + 165);
    ev(1'b1, r);
    chk("long_release_busy", kif.key_busy, 1'b0);
    wait_until(r + 60);

    // Release on the last PRESS1 cycle: no long press, single click instead
    ev(1'b0, p);
    wait_until(p + LONG_CYC);
    ev(1'b1, r);
    push(M_SINGLE, r + DCLICK_CYC + 1);
    wait_until(r + 60);
    chk("boundary_idle_busy", kif.key_busy, 1'b0);

    wait_until(cyc + 5);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
